log_alog_unit: RTL and testbench



---
 rtl/log_alog_unit.sv | 123 ++++++++++++
 tb/tb_log_alog_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/log_alog_unit.sv
`default_nettype none
// ============================================================================
// Module   : log_alog_unit
// Purpose  : Mitchell log2 of a (4,12) operand plus two Mitchell antilogs
//            (2^a at (1,18), 2^b at (1,19)); all results registered, latency 1.
//            Define LOG_ALOG_SAT_EN to saturate antilog overflow (else wrap).
// Revision : 1.0  initial release
// ============================================================================
module log_alog_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  logic [15:0] log_in,
    input  logic [17:0] alog18_in,
    input  logic [18:0] alog19_in,
    output logic        out_vld,
    output logic [4:0]  log_int,
    output logic [11:0] log_frac,
    output logic        log_valid,
    output logic [18:0] alog18_out,
    output logic [19:0] alog19_out
);

    // ------------------------------------------------------------------
    // Log path
    // ------------------------------------------------------------------
    logic [3:0]  w_k;
    logic [4:0]  w_log_int;
    logic [11:0] w_log_frac;
    logic        w_log_valid;

    always_comb begin
        w_k = 4'd0;
        for (int j = 0; j < 16; j++) begin
            if (log_in[j]) w_k = 4'(j);
        end
        w_log_valid = |log_in;
        w_log_int   = 5'd0;
        w_log_frac  = 12'd0;
        if (w_log_valid) begin
            // k - 12 in 5-bit two's complement
            w_log_int = {1'b0, w_k} + 5'd20;
            // Leading one is discarded by the 12-bit truncation in both branches
            if (w_k >= 4'd12) w_log_frac = 12'(log_in >> (w_k - 4'd12));
            else              w_log_frac = 12'(log_in << (4'd12 - w_k));
        end
    end

    // ------------------------------------------------------------------
    // Antilog 18: i in [17:12], shift s = i + 6
    // ------------------------------------------------------------------
    logic [6:0]  w_s18;
    logic [6:0]  w_nsh18;
    logic [18:0] w_m18;
    logic [18:0] w_alog18;

    always_comb begin
        w_s18   = {alog18_in[17], alog18_in[17:12]} + 7'd6;
        w_nsh18 = 7'd0 - w_s18;
        w_m18   = {6'd0, 1'b1, alog18_in[11:0]};
        if (!w_s18[6]) w_alog18 = w_m18 << w_s18;
        else           w_alog18 = w_m18 >> w_nsh18;
`ifdef LOG_ALOG_SAT_EN
        if (!alog18_in[17] && (alog18_in[16:12] != 5'd0)) w_alog18 = 19'h7FFFF;
`endif
    end

    // ------------------------------------------------------------------
    // Antilog 19: i in [18:12], shift s = i + 7
    // ------------------------------------------------------------------
    logic [7:0]  w_s19;
    logic [7:0]  w_nsh19;
    logic [19:0] w_m19;
    logic [19:0] w_alog19;

    always_comb begin
        w_s19   = {alog19_in[18], alog19_in[18:12]} + 8'd7;
        w_nsh19 = 8'd0 - w_s19;
        w_m19   = {7'd0, 1'b1, alog19_in[11:0]};
        if (!w_s19[7]) w_alog19 = w_m19 << w_s19;
        else           w_alog19 = w_m19 >> w_nsh19;
`ifdef LOG_ALOG_SAT_EN
        if (!alog19_in[18] && (alog19_in[17:12] != 6'd0)) w_alog19 = 20'hFFFFF;
`endif
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic        r_out_vld;
    logic [4:0]  r_log_int;
    logic [11:0] r_log_frac;
    logic        r_log_valid;
    logic [18:0] r_alog18;
    logic [19:0] r_alog19;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld   <= 1'b0;
            r_log_int   <= 5'd0;
            r_log_frac  <= 12'd0;
            r_log_valid <= 1'b0;
            r_alog18    <= 19'd0;
            r_alog19    <= 20'd0;
        end else begin
            r_out_vld   <= in_vld;
            r_log_int   <= w_log_int;
            r_log_frac  <= w_log_frac;
            r_log_valid <= w_log_valid;
            r_alog18    <= w_alog18;
            r_alog19    <= w_alog19;
        end
    end

    assign out_vld    = r_out_vld;
    assign log_int    = r_log_int;
    assign log_frac   = r_log_frac;
    assign log_valid  = r_log_valid;
    assign alog18_out = r_alog18;
    assign alog19_out = r_alog19;

endmodule
`default_nettype wire

// File: tb/tb_log_alog_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_alog_unit
// Purpose  : Directed self-checking bench for log_alog_unit (honours
//            LOG_ALOG_SAT_EN for overflow expectations).
// Revision : 1.0  initial release
// ============================================================================
module tb_log_alog_unit;

    logic        clk;
    logic        reset;
    logic        in_vld;
    logic [15:0] log_in;
    logic [17:0] alog18_in;
    logic [18:0] alog19_in;
    logic        out_vld;
    logic [4:0]  log_int;
    logic [11:0] log_frac;
    logic        log_valid;
    logic [18:0] alog18_out;
    logic [19:0] alog19_out;

    int checks   = 0;
    int failures = 0;

    log_alog_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_vld     (in_vld),
        .log_in     (log_in),
        .alog18_in  (alog18_in),
        .alog19_in  (alog19_in),
        .out_vld    (out_vld),
        .log_int    (log_int),
        .log_frac   (log_frac),
        .log_valid  (log_valid),
        .alog18_out (alog18_out),
        .alog19_out (alog19_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] li,
                         input logic [17:0] a18, input logic [18:0] a19);
        in_vld    = v;
        log_in    = li;
        alog18_in = a18;
        alog19_in = a19;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [4:0] li,
                             input logic [11:0] lf, input logic lv,
                             input logic [18:0] a18, input logic [19:0] a19);
        check({tag, ".out_vld"},    32'(out_vld),    32'(v));
        check({tag, ".log_int"},    32'(log_int),    32'(li));
        check({tag, ".log_frac"},   32'(log_frac),   32'(lf));
        check({tag, ".log_valid"},  32'(log_valid),  32'(lv));
        check({tag, ".alog18_out"}, 32'(alog18_out), 32'(a18));
        check({tag, ".alog19_out"}, 32'(alog19_out), 32'(a19));
    endtask

    logic [18:0] ovf18_exp;
    logic [19:0] ovf19_exp;

    initial begin
`ifdef LOG_ALOG_SAT_EN
        ovf18_exp = 19'h7FFFF;
        ovf19_exp = 20'hFFFFF;
`else
        ovf18_exp = 19'h00000;
        ovf19_exp = 20'h00000;
`endif
        reset = 1'b0;
        drive(1'b1, 16'h1000, 18'h00000, 19'h00000);
        tick();
        tick();
        check_all("reset", 1'b0, 5'd0, 12'd0, 1'b0, 19'd0, 20'd0);

        @(negedge clk);
        reset = 1'b1;

        // Log basics and antilog nominal values
        drive(1'b1, 16'h1000, 18'h3F000, 19'h00000);
        tick();
        check_all("v1000", 1'b1, 5'h00, 12'h000, 1'b1, 19'h20000, 20'h80000);

        drive(1'b0, 16'h1922, 18'h2C000, 19'h7A000);
        tick();
        check_all("v1922", 1'b0, 5'h00, 12'h922, 1'b1, 19'h00000, 20'h02000);

        drive(1'b1, 16'h0001, 18'h00800, 19'h7F800);
        tick();
        check_all("v0001", 1'b1, 5'h14, 12'h000, 1'b1, 19'h60000, 20'h60000);

        drive(1'b1, 16'hFFFF, 18'h3E400, 19'h6E123);
        tick();
        check_all("vFFFF", 1'b1, 5'h03, 12'hFFF, 1'b1, 19'h14000, 20'h00002);

        drive(1'b1, 16'h0000, 18'h2D800, 19'h00000);
        tick();
        check_all("vzero", 1'b1, 5'h00, 12'h000, 1'b0, 19'h00000, 20'h80000);

        // Overflow handling
        drive(1'b1, 16'h0800, 18'h01000, 19'h01000);
        tick();
        check_all("ovf", 1'b1, 5'h1F, 12'h000, 1'b1, ovf18_exp, ovf19_exp);

        // Back-to-back stream: inputs change right after each edge, so any
        // extra latency shows as the previous vector's results.
        drive(1'b0, 16'h2400, 18'h32FFF, 19'h00000);
        tick();
        check_all("s1", 1'b0, 5'h01, 12'h200, 1'b1, 19'h0001F, 20'h80000);
        drive(1'b1, 16'h0003, 18'h00000, 19'h7A000);
        #2;
        check("s2.hold_log_frac", 32'(log_frac), 32'h200);
        tick();
        check_all("s2", 1'b1, 5'h15, 12'h800, 1'b1, 19'h40000, 20'h02000);
        drive(1'b1, 16'h1922, 18'h3F000, 19'h7F800);
        tick();
        check_all("s3", 1'b1, 5'h00, 12'h922, 1'b1, 19'h20000, 20'h60000);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 5'd0, 12'd0, 1'b0, 19'd0, 20'd0);
        tick();
        check_all("rst_hold", 1'b0, 5'd0, 12'd0, 1'b0, 19'd0, 20'd0);

        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'hFFFF, 18'h00800, 19'h00000);
        tick();
        check_all("resume", 1'b1, 5'h03, 12'hFFF, 1'b1, 19'h60000, 20'h80000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
